universal_shift_register: RTL
=============================

Name: universal_shift_register

Overview:
Parametrised WIDTH-bit register with enable, asynchronous reset, synchronous preset, parallel load and serial shift left/right. A saturating shift counter raises Done after COUNT_LIMIT shifts. It is the register building block for the shift-add Multiplier datapath (multiplicand/multiplier/product registers) in the MIPS CPU, and generalises the single-bit enable/reset/preset flip-flop to a multi-mode vector register.

Parameters:
WIDTH, 32, register width in bits (>= 2)
PRESET_VALUE, {WIDTH{1'b1}}, value loaded by Preset
COUNT_LIMIT, WIDTH, number of shifts after which Done asserts (1..WIDTH)

Ports:
Clk  input  1  clock, all state changes on rising edge
Reset  input  1  asynchronous, active-high reset
Preset  input  1  synchronous preset, active-high
En  input  1  operation enable, active-high
Mode  input  2  00 hold, 01 parallel load, 10 shift left, 11 shift right
D  input  WIDTH  parallel load data
SerialInL  input  1  bit entering Q[0] on shift left
SerialInR  input  1  bit entering Q[WIDTH-1] on shift right
Q  output  WIDTH  register value
Qbar  output  WIDTH  bitwise complement of Q
ShiftOut  output  1  last bit shifted out
ShiftCount  output  $clog2(COUNT_LIMIT+1)  shifts performed since last load/preset/reset
Done  output  1  high when ShiftCount == COUNT_LIMIT

Behaviour:
- One clock (Clk). Reset is asynchronous and active-high. All outputs are registered. Qbar always equals ~Q.
- Reset=1, immediately and independent of Clk: Q=0, Qbar=all ones, ShiftOut=0, ShiftCount=0, Done=0. Reset asserted mid-operation aborts any shift sequence.
- Per rising edge, priority is Reset > Preset > En=0 > Mode.
- Preset=1: Q=PRESET_VALUE, ShiftCount=0, Done=0, ShiftOut=0. This applies regardless of En and Mode.
- En=0: all state holds.
- Mode 00 (hold): all state holds.
- Mode 01 (load): Q=D, ShiftCount=0, Done=0, ShiftOut=0.
- Mode 10 (shift left): Q={Q[WIDTH-2:0],SerialInL}, ShiftOut=Q[WIDTH-1] (pre-shift), ShiftCount+1.
- Mode 11 (shift right): Q={SerialInR,Q[WIDTH-1:1]}, ShiftOut=Q[0] (pre-shift), ShiftCount+1.
- Latency: the result is visible one cycle after the qualifying edge.
- Done is registered and asserts on the edge where ShiftCount becomes COUNT_LIMIT.
- While Done=1, shift commands are ignored: Q, ShiftOut and ShiftCount hold, and the counter saturates with no wrap. Only load, Preset or Reset clear Done.
- Left and right shifts may be mixed. Every accepted shift increments the same counter.

Optional Feature:
Macro USR_ROTATE_EN.
- Defined: adds input port Rotate (1 bit). When Rotate=1 during a shift, the outgoing bit re-enters the other end: left shift gives {Q[WIDTH-2:0],Q[WIDTH-1]}, right shift gives {Q[0],Q[WIDTH-1:1]}. SerialInL/SerialInR are ignored. ShiftOut and the counter behave as for a normal shift.
- Undefined: no Rotate port; shifts always take SerialInL/SerialInR.

Decomposition:
- Package usr_pkg holds:
  - Mode encoding constants MODE_HOLD=2'b00, MODE_LOAD=2'b01, MODE_SHL=2'b10, MODE_SHR=2'b11.
  - A function computing the counter width from COUNT_LIMIT.
- Sub-module shift_counter (parameter LIMIT) owns:
  - Inputs: Clk, Reset, Clear (load/preset), Inc (accepted shift).
  - Outputs: Count, Done (saturating).
- The top level holds the data register, mode mux and ShiftOut.

Test Plan (WIDTH=8, COUNT_LIMIT=8 unless noted):
- Reset=1 mid-shift, asynchronously between edges -> Q=8'h00, Qbar=8'hFF, Count=0, Done=0 with no clock edge needed.
- Load D=8'hA5, then En=0 for 3 cycles with Mode=10 -> Q stays 8'hA5, Count=0.
- Load 8'h81, shift left with SerialInL=0 -> Q=8'h02, ShiftOut=1, Count=1; then shift right with SerialInR=1 -> Q=8'h81, ShiftOut=0, Count=2.
- Load 8'h01, 8 right shifts with SerialInR=0 -> Q=8'h00, Done=1 after the 8th edge; a 9th shift command -> Q, ShiftOut and Count=8 unchanged.
- Preset and Mode=01 (D=8'h3C) on the same edge -> Q=8'hFF (PRESET_VALUE wins), Done cleared; then Preset with En=0 -> Q=8'hFF.
- USR_ROTATE_EN defined, load 8'h81, Rotate=1, shift left -> Q=8'h03, ShiftOut=1; shift right -> Q=8'h81.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the shift-counter width helper.
package usr_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_SHR  = 2'b11;

    // Bits needed to hold the values 0..limit inclusive.
    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/shift_counter.sv
// Saturating shift counter: counts accepted shifts up to LIMIT and raises
// Done on the edge where the count reaches LIMIT.
module shift_counter
    import usr_pkg::*;
#(
    parameter int LIMIT = 32,
    parameter int CW    = cnt_width(LIMIT)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Clear,
    input  logic          Inc,
    output logic [CW-1:0] Count,
    output logic          Done
);

    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] r_count;
    logic          r_done;
    logic [CW-1:0] w_next;

    assign w_next = r_count + CW'(1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (Clear) begin
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (Inc && !r_done) begin
            r_count <= w_next;
            r_done  <= (w_next == LIM);
        end
    end

    assign Count = r_count;
    assign Done  = r_done;

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit register with preset, parallel load and serial shift left/right,
// plus a saturating shift counter. Define USR_ROTATE_EN to add the Rotate input.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}},
    parameter int               COUNT_LIMIT  = WIDTH,
    parameter int               CW           = cnt_width(COUNT_LIMIT)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Preset,
    input  logic             En,
    input  logic [1:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SerialInL,
    input  logic             SerialInR,
`ifdef USR_ROTATE_EN
    input  logic             Rotate,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic             ShiftOut,
    output logic [CW-1:0]    ShiftCount,
    output logic             Done
);

    logic [WIDTH-1:0] r_q;
    logic             r_shout;
    logic             w_done;
    logic             w_load;
    logic             w_shift;
    logic             w_in_l;
    logic             w_in_r;

    // Load and preset both restart the shift sequence; shifts stop once Done.
    assign w_load  = Preset || (En && (Mode == MODE_LOAD));
    assign w_shift = !Preset && En && Mode[1] && !w_done;

`ifdef USR_ROTATE_EN
    assign w_in_l = Rotate ? r_q[WIDTH-1] : SerialInL;
    assign w_in_r = Rotate ? r_q[0]       : SerialInR;
`else
    assign w_in_l = SerialInL;
    assign w_in_r = SerialInR;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_q     <= '0;
            r_shout <= 1'b0;
        end else if (Preset) begin
            r_q     <= PRESET_VALUE;
            r_shout <= 1'b0;
        end else if (w_load) begin
            r_q     <= D;
            r_shout <= 1'b0;
        end else if (w_shift) begin
            if (Mode == MODE_SHL) begin
                r_q     <= {r_q[WIDTH-2:0], w_in_l};
                r_shout <= r_q[WIDTH-1];
            end else begin
                r_q     <= {w_in_r, r_q[WIDTH-1:1]};
                r_shout <= r_q[0];
            end
        end
    end

    shift_counter #(
        .LIMIT (COUNT_LIMIT),
        .CW    (CW)
    ) u_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .Clear (w_load),
        .Inc   (w_shift),
        .Count (ShiftCount),
        .Done  (w_done)
    );

    assign Q        = r_q;
    assign Qbar     = ~r_q;
    assign ShiftOut = r_shout;
    assign Done     = w_done;

endmodule
